// File: rtl/mkt_feed_parser_mc.sv
// mkt_feed_parser_mc
// Frames fixed-length market messages from an 8-bit AXI-Stream UDP payload.
// Each message is {symbol, price (MSB first), volume (MSB first)}. The block
// checks each message against runtime-writable buy/sell thresholds for that
// symbol. A crossing loads a back-pressured event register and retriggers a
// stretched LED for that symbol. Short, long and unknown-symbol packets are
// dropped.
//
// Optional feature: define PARSER_ERR_CNT_EN to add the err_short, err_long
// and err_unknown ports and their saturating counters.
//
// Ports:
//   axis_aclk, axis_aresetn   clock, synchronous active-low reset
//   s00_axis_*                payload byte stream (tdata/tvalid/tready/tlast)
//   thr_wr_*                  threshold write (sym, sel 0=buy 1=sell, data)
//   m_evt_*                   event stream (valid/ready, sym, side, price, volume)
//   buy_led, sell_led         per-symbol stretched crossing indicators
//   err_*                     saturating drop counters (optional)

// One symbol's slice: its thresholds, its compare and its two LED stretchers.
module mkt_sym_chan #(
   parameter int PULSE_CYCLES = 6000000
) (
   input  logic        axis_aclk,
   input  logic        axis_aresetn,
   input  logic        buy_we,
   input  logic        sell_we,
   input  logic [31:0] thr_data,
   input  logic [31:0] price,
   input  logic        buy_fire,
   input  logic        sell_fire,
   output logic        buy_hit,
   output logic        sell_hit,
   output logic        buy_led,
   output logic        sell_led
);
   localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

   logic [31:0]      buy_thr, sell_thr;
   logic [CNT_W-1:0] buy_cnt, sell_cnt;

   assign buy_hit  = price > buy_thr;
   assign sell_hit = price < sell_thr;

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         buy_thr  <= 32'hFFFF_FFFF;   // never buy
         sell_thr <= 32'h0000_0000;   // never sell
         buy_cnt  <= '0;
         sell_cnt <= '0;
         buy_led  <= 1'b0;
         sell_led <= 1'b0;
      end else begin
         if (buy_we)  buy_thr  <= thr_data;
         if (sell_we) sell_thr <= thr_data;
         // A new hit reloads the full count, even in the middle of a pulse.
         if (buy_fire)             buy_cnt <= CNT_W'(PULSE_CYCLES);
         else if (buy_cnt != '0)   buy_cnt <= buy_cnt - CNT_W'(1);
         if (sell_fire)            sell_cnt <= CNT_W'(PULSE_CYCLES);
         else if (sell_cnt != '0)  sell_cnt <= sell_cnt - CNT_W'(1);
         buy_led  <= buy_cnt != '0;
         sell_led <= sell_cnt != '0;
      end
   end
endmodule

module mkt_feed_parser_mc #(
   parameter int NUM_SYMBOLS  = 4,
   parameter int PRICE_BYTES  = 4,
   parameter int VOL_BYTES    = 4,
   parameter int PULSE_CYCLES = 6000000,
   parameter int SYM_W        = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1
) (
   input  logic                   axis_aclk,
   input  logic                   axis_aresetn,
   input  logic [7:0]             s00_axis_tdata,
   input  logic                   s00_axis_tvalid,
   output logic                   s00_axis_tready,
   input  logic                   s00_axis_tlast,
   input  logic                   thr_wr_en,
   input  logic [SYM_W-1:0]       thr_wr_sym,
   input  logic                   thr_wr_sel,
   input  logic [31:0]            thr_wr_data,
   output logic                   m_evt_valid,
   input  logic                   m_evt_ready,
   output logic [7:0]             m_evt_sym,
   output logic [1:0]             m_evt_side,
   output logic [31:0]            m_evt_price,
   output logic [31:0]            m_evt_volume,
   output logic [NUM_SYMBOLS-1:0] buy_led,
   output logic [NUM_SYMBOLS-1:0] sell_led
`ifdef PARSER_ERR_CNT_EN
   ,
   output logic [15:0]            err_short,
   output logic [15:0]            err_long,
   output logic [15:0]            err_unknown
`endif
);
   localparam logic [1:0] PRICE_LAST = 2'(PRICE_BYTES - 1);
   localparam logic [1:0] VOL_LAST   = 2'(VOL_BYTES - 1);

   typedef enum logic [1:0] {S_SYM, S_PRICE, S_VOL, S_DRAIN} state_t;

   state_t      state;
   logic [1:0]  cnt;        // byte index within the current field
   logic [7:0]  sym_r;
   logic [31:0] price_r, vol_r;
   logic        cmt_vld;    // a complete, exact-length message is held in sym_r/price_r/vol_r
   logic        acc;

   logic [NUM_SYMBOLS-1:0] buy_hit_v, sell_hit_v, buy_fire, sell_fire, buy_we, sell_we;
   logic                   sel_buy, sel_sell, evt_load;

   assign s00_axis_tready = !m_evt_valid || m_evt_ready;
   assign acc             = s00_axis_tvalid && s00_axis_tready;

   // Framing FSM. Fields shift in MSB first; clearing at symbol capture
   // leaves the upper bytes zero when a field is narrower than 32 bits.
   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state   <= S_SYM;
         cnt     <= '0;
         sym_r   <= '0;
         price_r <= '0;
         vol_r   <= '0;
         cmt_vld <= 1'b0;
      end else begin
         cmt_vld <= 1'b0;
         if (acc) begin
            case (state)
               S_SYM: begin
                  sym_r   <= s00_axis_tdata;
                  price_r <= '0;
                  vol_r   <= '0;
                  cnt     <= '0;
                  state   <= s00_axis_tlast ? S_SYM : S_PRICE;
               end
               S_PRICE: begin
                  price_r <= {price_r[23:0], s00_axis_tdata};
                  if (s00_axis_tlast) begin
                     state <= S_SYM;
                  end else if (cnt == PRICE_LAST) begin
                     cnt   <= '0;
                     state <= S_VOL;
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
               S_VOL: begin
                  vol_r <= {vol_r[23:0], s00_axis_tdata};
                  if (cnt == VOL_LAST) begin
                     cnt <= '0;
                     if (s00_axis_tlast) begin
                        state   <= S_SYM;
                        cmt_vld <= 1'b1;
                     end else begin
                        state <= S_DRAIN;
                     end
                  end else if (s00_axis_tlast) begin
                     state <= S_SYM;
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
               default: begin
                  if (s00_axis_tlast) state <= S_SYM;
               end
            endcase
         end
      end
   end

   // Pick the committed symbol's compare results; an unknown symbol matches
   // no slice and so yields no hit.
   always_comb begin
      sel_buy  = 1'b0;
      sel_sell = 1'b0;
      for (int k = 0; k < NUM_SYMBOLS; k++) begin
         if (sym_r == 8'(k)) begin
            sel_buy  = buy_hit_v[k];
            sel_sell = sell_hit_v[k];
         end
      end
   end

   assign evt_load = cmt_vld && (sel_buy || sel_sell);

   for (genvar k = 0; k < NUM_SYMBOLS; k++) begin : g_chan
      assign buy_we[k]    = thr_wr_en && !thr_wr_sel && (thr_wr_sym == SYM_W'(k));
      assign sell_we[k]   = thr_wr_en &&  thr_wr_sel && (thr_wr_sym == SYM_W'(k));
      assign buy_fire[k]  = cmt_vld && (sym_r == 8'(k)) && buy_hit_v[k];
      assign sell_fire[k] = cmt_vld && (sym_r == 8'(k)) && sell_hit_v[k];

      mkt_sym_chan #(.PULSE_CYCLES(PULSE_CYCLES)) u_chan (
         .axis_aclk    (axis_aclk),
         .axis_aresetn (axis_aresetn),
         .buy_we       (buy_we[k]),
         .sell_we      (sell_we[k]),
         .thr_data     (thr_wr_data),
         .price        (price_r),
         .buy_fire     (buy_fire[k]),
         .sell_fire    (sell_fire[k]),
         .buy_hit      (buy_hit_v[k]),
         .sell_hit     (sell_hit_v[k]),
         .buy_led      (buy_led[k]),
         .sell_led     (sell_led[k])
      );
   end

   // Event register: a load wins over a same-cycle handshake clear.
   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         m_evt_valid  <= 1'b0;
         m_evt_sym    <= '0;
         m_evt_side   <= '0;
         m_evt_price  <= '0;
         m_evt_volume <= '0;
      end else if (evt_load) begin
         m_evt_valid  <= 1'b1;
         m_evt_sym    <= sym_r;
         m_evt_side   <= {sel_sell, sel_buy};
         m_evt_price  <= price_r;
         m_evt_volume <= vol_r;
      end else if (m_evt_ready) begin
         m_evt_valid <= 1'b0;
      end
   end

`ifdef PARSER_ERR_CNT_EN
   logic short_hit, long_hit, unk_hit;

   assign short_hit = acc && s00_axis_tlast &&
                      ((state == S_SYM) || (state == S_PRICE) ||
                       ((state == S_VOL) && (cnt != VOL_LAST)));
   assign long_hit  = acc && !s00_axis_tlast && (state == S_VOL) && (cnt == VOL_LAST);
   assign unk_hit   = cmt_vld && ({1'b0, sym_r} >= 9'(NUM_SYMBOLS));

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         err_short   <= '0;
         err_long    <= '0;
         err_unknown <= '0;
      end else begin
         if (short_hit && err_short   != 16'hFFFF) err_short   <= err_short   + 16'd1;
         if (long_hit  && err_long    != 16'hFFFF) err_long    <= err_long    + 16'd1;
         if (unk_hit   && err_unknown != 16'hFFFF) err_unknown <= err_unknown + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mkt_feed_parser_mc.sv
module tb_mkt_feed_parser_mc;
   localparam int NS      = 4;
   localparam int PB      = 4;
   localparam int VB      = 4;
   localparam int PULSE   = 16;
   localparam int MSG_LEN = 1 + PB + VB;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0]  sym;
      logic [1:0]  side;
      logic [31:0] price;
      logic [31:0] vol;
      int          n;      // cycle index of the edge that took the final byte
   } evt_t;

   logic        axis_aclk = 0;
   logic        axis_aresetn = 0;
   logic [7:0]  s00_axis_tdata = 0;
   logic        s00_axis_tvalid = 0;
   logic        s00_axis_tready;
   logic        s00_axis_tlast = 0;
   logic        thr_wr_en = 0;
   logic [1:0]  thr_wr_sym = 0;
   logic        thr_wr_sel = 0;
   logic [31:0] thr_wr_data = 0;
   logic        m_evt_valid;
   logic        m_evt_ready = 1;
   logic [7:0]  m_evt_sym;
   logic [1:0]  m_evt_side;
   logic [31:0] m_evt_price, m_evt_volume;
   logic [NS-1:0] buy_led, sell_led;
`ifdef PARSER_ERR_CNT_EN
   logic [15:0] err_short, err_long, err_unknown;
`endif

   mkt_feed_parser_mc #(.NUM_SYMBOLS(NS), .PRICE_BYTES(PB), .VOL_BYTES(VB), .PULSE_CYCLES(PULSE)) dut (
      .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
      .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
      .s00_axis_tready(s00_axis_tready), .s00_axis_tlast(s00_axis_tlast),
      .thr_wr_en(thr_wr_en), .thr_wr_sym(thr_wr_sym), .thr_wr_sel(thr_wr_sel),
      .thr_wr_data(thr_wr_data),
      .m_evt_valid(m_evt_valid), .m_evt_ready(m_evt_ready), .m_evt_sym(m_evt_sym),
      .m_evt_side(m_evt_side), .m_evt_price(m_evt_price), .m_evt_volume(m_evt_volume),
      .buy_led(buy_led), .sell_led(sell_led)
`ifdef PARSER_ERR_CNT_EN
      , .err_short(err_short), .err_long(err_long), .err_unknown(err_unknown)
`endif
   );

   always #5 axis_aclk = ~axis_aclk;

   int cyc = 0;
   always @(posedge axis_aclk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   bit mon_en = 0, gap_en = 0;
   int rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

   // reference model state
   logic [31:0] m_buy[NS], m_sell[NS];
   int bh_last[NS], bh_prev[NS], sh_last[NS], sh_prev[NS];
   int m_short = 0, m_long = 0, m_unk = 0;
   evt_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NS; k++) begin
         m_buy[k] = 32'hFFFF_FFFF; m_sell[k] = 0;
         bh_last[k] = -1000; bh_prev[k] = -1000; sh_last[k] = -1000; sh_prev[k] = -1000;
      end
      m_short = 0; m_long = 0; m_unk = 0;
      exp_q.delete();
   endtask

   // LED for a hit taken at edge h is on from edge h+2 to edge h+1+PULSE.
   function automatic bit in_win(input int h);
      return (cyc - h) >= 2 && (cyc - h) <= PULSE + 1;
   endfunction

   function automatic bq_t msg(input logic [7:0] sym, input logic [31:0] price, input logic [31:0] vol);
      bq_t q;
      q.push_back(sym);
      for (int i = PB - 1; i >= 0; i--) q.push_back(price[8*i +: 8]);
      for (int i = VB - 1; i >= 0; i--) q.push_back(vol[8*i +: 8]);
      return q;
   endfunction

   task automatic model_pkt(input bq_t p, input int n);
      logic [31:0] price, vol;
      int sym;
      bit b, s;
      evt_t e;
      if (p.size() < MSG_LEN) m_short++;
      else if (p.size() > MSG_LEN) m_long++;
      else begin
         sym = int'(p[0]); price = 0; vol = 0;
         for (int i = 1; i <= PB; i++) price = (price << 8) | 32'(p[i]);
         for (int i = PB + 1; i <= PB + VB; i++) vol = (vol << 8) | 32'(p[i]);
         if (sym >= NS) m_unk++;
         else begin
            b = price > m_buy[sym];
            s = price < m_sell[sym];
            if (b || s) begin
               e.sym = 8'(sym); e.side = {s, b}; e.price = price; e.vol = vol; e.n = n;
               exp_q.push_back(e);
            end
            if (b) begin bh_prev[sym] = bh_last[sym]; bh_last[sym] = n; end
            if (s) begin sh_prev[sym] = sh_last[sym]; sh_last[sym] = n; end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, output int n);
      int t = 0;
      bit a = 0;
      if (gap_en && $urandom_range(0, 3) == 0) @(negedge axis_aclk);
      @(negedge axis_aclk);
      s00_axis_tvalid = 1; s00_axis_tdata = d; s00_axis_tlast = last;
      while (!a && t < 200) begin
         #1 a = s00_axis_tready;
         @(posedge axis_aclk);
         if (!a) begin t++; @(negedge axis_aclk); end
      end
      #1;
      n = cyc;
      s00_axis_tvalid = 0; s00_axis_tlast = 0;
      if (!a) chk("byte_accept_timeout", 0, 1);
   endtask

   task automatic send_pkt(input bq_t p);
      int n = 0;
      for (int i = 0; i < p.size(); i++) send_byte(p[i], i == p.size() - 1, n);
      model_pkt(p, n);
   endtask

   task automatic wr_thr(input int sym, input bit sel, input logic [31:0] val);
      @(negedge axis_aclk);
      thr_wr_en = 1; thr_wr_sym = 2'(sym); thr_wr_sel = sel; thr_wr_data = val;
      @(posedge axis_aclk);
      #1 thr_wr_en = 0;
      if (sel) m_sell[sym] = val; else m_buy[sym] = val;
   endtask

   task automatic wait_cyc(input int k);
      repeat (k) @(negedge axis_aclk);
   endtask

   // event-ready driver
   initial forever begin
      @(negedge axis_aclk);
      case (rdy_mode)
         0: m_evt_ready = ($urandom_range(0, 3) != 0);
         1: m_evt_ready = 0;
         default: m_evt_ready = 1;
      endcase
   end

   // continuous monitor against the model
   initial forever begin
      @(negedge axis_aclk);
      #1;
      if (mon_en) begin
         chk("tready", s00_axis_tready, !m_evt_valid || m_evt_ready);
         chk("evt_valid", m_evt_valid, exp_q.size() > 0 && cyc >= exp_q[0].n + 1);
         if (m_evt_valid && m_evt_ready && exp_q.size() > 0) begin
            chk("evt_sym", m_evt_sym, exp_q[0].sym);
            chk("evt_side", m_evt_side, exp_q[0].side);
            chk("evt_price", m_evt_price, exp_q[0].price);
            chk("evt_volume", m_evt_volume, exp_q[0].vol);
            void'(exp_q.pop_front());
         end
         for (int k = 0; k < NS; k++) begin
            chk($sformatf("buy_led%0d", k), buy_led[k], in_win(bh_last[k]) || in_win(bh_prev[k]));
            chk($sformatf("sell_led%0d", k), sell_led[k], in_win(sh_last[k]) || in_win(sh_prev[k]));
         end
      end
   end

   initial begin
      bq_t p;
      int cnt, lim;
      int n = 0;
      logic [7:0] hs;
      logic [31:0] hp;
      model_reset();
      wait_cyc(3);
      #1;
      chk("rst_tready", s00_axis_tready, 1);
      chk("rst_valid", m_evt_valid, 0);
      chk("rst_evt_data", {m_evt_sym, m_evt_side, m_evt_price}, 0);
      chk("rst_evt_vol", m_evt_volume, 0);
      chk("rst_leds", {buy_led, sell_led}, 0);
`ifdef PARSER_ERR_CNT_EN
      chk("rst_errs", {err_short, err_long, err_unknown}, 0);
`endif
      axis_aresetn = 1;
      mon_en = 1;
      wait_cyc(2);

      // basic buy crossing, event held to inspect it and the LED stretch
      wr_thr(2, 0, 32'h0064_0000);
      rdy_mode = 1;
      send_pkt('{8'h02, 8'h00, 8'h65, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'hE8});
      wait_cyc(2);
      #2;
      chk("t1_valid", m_evt_valid, 1);
      chk("t1_sym", m_evt_sym, 2);
      chk("t1_side", m_evt_side, 2'b01);
      chk("t1_price", m_evt_price, 32'h0065_0000);
      chk("t1_volume", m_evt_volume, 1000);
      cnt = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge axis_aclk); #2;
         if (buy_led[2]) cnt++;
         chk("t1_sell_led", sell_led, 0);
      end
      chk("t1_led_len", cnt, PULSE);
      rdy_mode = 2;
      wait_cyc(2);

      // short packet, then a good one
      send_pkt('{8'h02, 8'h00, 8'h70, 8'h00, 8'h00});
      send_pkt(msg(2, 32'h0070_0000, 32'd55));
      wait_cyc(4);
`ifdef PARSER_ERR_CNT_EN
      chk("t2_err_short", err_short, 1);
`endif

      // long packet, then a good one
      send_pkt('{8'h02, 8'h00, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC});
      send_pkt(msg(2, 32'h0080_0000, 32'd77));
      wait_cyc(4);
`ifdef PARSER_ERR_CNT_EN
      chk("t3_err_long", err_long, 1);
`endif

      // unknown symbol
      send_pkt(msg(7, 32'hFFFF_0000, 32'd9));
      wait_cyc(4);
`ifdef PARSER_ERR_CNT_EN
      chk("t4_err_unknown", err_unknown, 1);
`endif
      wait_cyc(PULSE);

      // back-pressure: hold the event, the next packet must stall
      wr_thr(3, 0, 32'h0000_0010);
      rdy_mode = 1;
      send_pkt(msg(2, 32'h0090_0000, 32'd123));
      wait_cyc(2);
      #2;
      hs = m_evt_sym; hp = m_evt_price;
      chk("t5_held_sym", hs, 2);
      fork
         send_pkt(msg(3, 32'h0000_0020, 32'd456));
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge axis_aclk); #2;
               chk("t5_hold_valid", m_evt_valid, 1);
               chk("t5_hold_tready", s00_axis_tready, 0);
               chk("t5_hold_sym", m_evt_sym, hs);
               chk("t5_hold_price", m_evt_price, hp);
            end
            rdy_mode = 2;
         end
      join
      wait_cyc(PULSE + 4);

      // both sides crossed, then a retrigger mid-pulse
      wr_thr(0, 1, 32'h0050_0000);
      wr_thr(0, 0, 32'h0010_0000);
      rdy_mode = 1;
      send_pkt(msg(0, 32'h0030_0000, 32'd5));
      wait_cyc(2);
      #2;
      chk("t6_side", m_evt_side, 2'b11);
      rdy_mode = 2;
      send_pkt(msg(0, 32'h0030_0000, 32'd6));
      wait_cyc(10);
      #2;
      chk("t6_retrig_buy", buy_led[0], 1);
      chk("t6_retrig_sell", sell_led[0], 1);
      wait_cyc(PULSE + 4);

      // reset in the middle of a packet
      send_byte(8'h01, 0, n);
      send_byte(8'h00, 0, n);
      send_byte(8'h00, 0, n);
      @(negedge axis_aclk);
      axis_aresetn = 0;
      @(posedge axis_aclk);
      #1 model_reset();
      @(negedge axis_aclk);
      axis_aresetn = 1;
      #2;
      chk("rst2_leds", {buy_led, sell_led}, 0);
`ifdef PARSER_ERR_CNT_EN
      chk("rst2_errs", {err_short, err_long, err_unknown}, 0);
`endif
      wr_thr(1, 0, 32'h0000_0000);
      send_pkt(msg(1, 32'h0000_0005, 32'd42));
      wait_cyc(4);

      // randomized traffic
      gap_en = 1;
      rdy_mode = 0;
      for (int i = 0; i < 250; i++) begin
         int r = $urandom_range(0, 99);
         int sym = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
         logic [31:0] pr = 32'h100 + $urandom_range(0, 64);
         p = msg(8'(sym), pr, $urandom);
         if (r < 15) begin
            lim = $urandom_range(1, MSG_LEN - 1);
            while (p.size() > lim) void'(p.pop_back());
         end else if (r < 30) begin
            lim = $urandom_range(MSG_LEN + 1, MSG_LEN + 4);
            while (p.size() < lim) p.push_back(8'($urandom));
         end
         send_pkt(p);
         if ($urandom_range(0, 4) == 0)
            wr_thr($urandom_range(0, NS - 1), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h100 + $urandom_range(0, 64));
      end
      gap_en = 0;
      rdy_mode = 2;
      lim = 0;
      while (exp_q.size() > 0 && lim < 100) begin @(negedge axis_aclk); lim++; end
      chk("drain_events", exp_q.size(), 0);
`ifdef PARSER_ERR_CNT_EN
      chk("end_err_short", err_short, m_short);
      chk("end_err_long", err_long, m_long);
      chk("end_err_unknown", err_unknown, m_unk);
`endif
      wait_cyc(PULSE + 4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mkt_feed_parser_mc.md
# mkt_feed_parser_mc

Multi-symbol, parametrised successor to the single-symbol threshold parser: consumes the 8-bit AXI-Stream UDP payload from the UDP/IP core, frames fixed-length messages (symbol, big-endian price, big-endian volume), and enforces exact message length. It compares each valid message against per-symbol runtime-writable buy/sell thresholds. Crossings are emitted on a back-pressured event stream and drive per-symbol stretched LEDs; malformed and unknown-symbol packets are dropped.

## Interface
- NUM_SYMBOLS, 4: symbols tracked (ids 0..NUM_SYMBOLS-1), 1..256.
- PRICE_BYTES, 4: price field bytes, 1..4; zero-extended to 32 bits.
- VOL_BYTES, 4: volume field bytes, 1..4; zero-extended to 32 bits.
- PULSE_CYCLES, 6000000: LED stretch length in clocks, >=1.
- SYM_W, derived, clog2(NUM_SYMBOLS) min 1: threshold write address width.

Ports:
- axis_aclk  in  1  sole clock.
- axis_aresetn  in  1  synchronous, active-low reset.
- s00_axis_tdata  in  8  payload byte.
- s00_axis_tvalid  in  1  byte valid.
- s00_axis_tready  out  1  byte accept.
- s00_axis_tlast  in  1  last payload byte of UDP packet.
- thr_wr_en  in  1  threshold write strobe.
- thr_wr_sym  in  SYM_W  symbol to write.
- thr_wr_sel  in  1  0 = buy threshold, 1 = sell threshold.
- thr_wr_data  in  32  threshold value, unsigned Q16.16.
- m_evt_valid  out  1  event valid.
- m_evt_ready  in  1  event accept.
- m_evt_sym  out  8  symbol id.
- m_evt_side  out  2  bit0 buy (price > buy_thr), bit1 sell (price < sell_thr).
- m_evt_price  out  32  price.
- m_evt_volume  out  32  volume.
- buy_led  out  NUM_SYMBOLS  per-symbol stretched buy indicator.
- sell_led  out  NUM_SYMBOLS  per-symbol stretched sell indicator.
- err_short, err_long, err_unknown  out  16 each  saturating counters (PARSER_ERR_CNT_EN only).

## Operation
- MSG_LEN = 1 + PRICE_BYTES + VOL_BYTES. A byte transfers when tvalid && tready.
- s00_axis_tready = !m_evt_valid || m_evt_ready; input stalls only while an event is pending.
- FSM: S_SYM (capture symbol), S_PRICE (PRICE_BYTES bytes, MSB first), S_VOL (VOL_BYTES bytes, MSB first), S_DRAIN (discard to tlast). A byte counter tracks position within a field.
- tlast on any byte before byte MSG_LEN: short packet; discard the partial message, go to S_SYM, increment err_short.
- Byte MSG_LEN with tlast: message commits.
- Byte MSG_LEN without tlast: go to S_DRAIN; discard all bytes through tlast, then go to S_SYM; no commit; increment err_long once per packet.
- Commit with symbol >= NUM_SYMBOLS: dropped; increment err_unknown; no event and no LED change.
- Commit with a known symbol: compare unsigned against that symbol's thresholds. If buy || sell, load the event register. If neither, no event.
- Buy and sell both true (thresholds crossed): m_evt_side = 2'b11; both LEDs fire.
- Event register holds stable while m_evt_valid && !m_evt_ready. Cleared on the handshake unless a new commit loads it in the same cycle.
- LED: a buy/sell hit on symbol k reloads that LED's counter to PULSE_CYCLES (retrigger restarts the count); the counter decrements to 0. led[k] = counter != 0, registered.
- Threshold write takes effect for commits 1+ cycles later. A write in the commit cycle does not affect that compare (old value used). Writes with thr_wr_sym >= NUM_SYMBOLS are ignored.

## Timing
- Reset values: FSM S_SYM, s00_axis_tready 1, m_evt_valid 0, m_evt_* data 0, buy_led/sell_led 0, all LED counters 0, all error counters 0.
- Threshold reset values: buy thresholds 32'hFFFF_FFFF (never buy), sell thresholds 0 (never sell).
- Final byte accepted at edge N: m_evt_valid high after edge N+1; LED counter loaded at N+1; led high after N+2.
- Reset asserted mid-packet: packet abandoned, no event. The bytes that follow reset are parsed as a new message starting at S_SYM.
- Error counters saturate at 16'hFFFF.

## Configuration
- PARSER_ERR_CNT_EN defined: err_short, err_long, err_unknown ports and counters present.
- PARSER_ERR_CNT_EN undefined: ports and counters absent. Error drop behaviour is identical.

## Test plan
- Write buy_thr[2]=0x00640000. Send packet {02, 00 65 00 00, 00 00 03 E8} with tlast on byte 9 -> one event: sym 2, side 01, price 0x00650000, volume 1000; buy_led[2] high for PULSE_CYCLES (bench PULSE_CYCLES=16); sell_led stays 0.
- 5-byte packet with tlast on byte 5, then a valid packet -> err_short=1, no event for the first, correct event for the second.
- 12-byte packet -> err_long=1, no event; the next valid packet parses correctly.
- Symbol 7 with NUM_SYMBOLS=4 -> err_unknown=1, no event, LEDs unchanged.
- Hold m_evt_ready=0 after an event -> s00_axis_tready=0, event fields stable. Release -> one handshake, tready returns to 1, no byte lost.
- Set sell_thr[0]=0x00500000 and buy_thr[0]=0x00100000. Send price 0x00300000 -> side 11, both LEDs for symbol 0 high. A retrigger mid-pulse restarts the full count.
